// File: rtl/adder_sub_16bit.sv
// 16-bit add/sub built from four 4-bit CLA groups, registered result.
// Build with SATURATE_ARITH_EN defined to clamp the sum on signed overflow.
module adder_sub_16bit (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        is_sub,
    output logic        out_valid,
    output logic [15:0] sum,
    output logic        ovfl,
    output logic        cout
);

    logic [15:0] b_eff;
    logic [15:0] g;
    logic [15:0] p;
    logic [15:0] carry;
    logic [3:0]  grp_g;
    logic [3:0]  grp_p;
    logic [4:0]  gc;
    logic [15:0] raw_sum;
    logic        ovfl_raw;
    logic [15:0] sum_d;

    assign b_eff = b ^ {16{is_sub}};
    assign g     = a & b_eff;
    assign p     = a ^ b_eff;

    for (genvar gi = 0; gi < 4; gi++) begin : grp
        logic [3:0] bg;
        logic [3:0] bp;
        logic       ci;

        assign bg = g[4*gi +: 4];
        assign bp = p[4*gi +: 4];
        assign ci = gc[gi];

        assign carry[4*gi]   = ci;
        assign carry[4*gi+1] = bg[0] | (bp[0] & ci);
        assign carry[4*gi+2] = bg[1] | (bp[1] & bg[0])
                             | (bp[1] & bp[0] & ci);
        assign carry[4*gi+3] = bg[2] | (bp[2] & bg[1])
                             | (bp[2] & bp[1] & bg[0])
                             | (bp[2] & bp[1] & bp[0] & ci);

        assign grp_g[gi] = bg[3] | (bp[3] & bg[2])
                         | (bp[3] & bp[2] & bg[1])
                         | (bp[3] & bp[2] & bp[1] & bg[0]);
        assign grp_p[gi] = &bp;
    end

    // Group-level lookahead: all group carries from G/P and cin in parallel
    assign gc[0] = is_sub;
    assign gc[1] = grp_g[0] | (grp_p[0] & gc[0]);
    assign gc[2] = grp_g[1] | (grp_p[1] & grp_g[0])
                 | (grp_p[1] & grp_p[0] & gc[0]);
    assign gc[3] = grp_g[2] | (grp_p[2] & grp_g[1])
                 | (grp_p[2] & grp_p[1] & grp_g[0])
                 | (grp_p[2] & grp_p[1] & grp_p[0] & gc[0]);
    assign gc[4] = grp_g[3] | (grp_p[3] & grp_g[2])
                 | (grp_p[3] & grp_p[2] & grp_g[1])
                 | (grp_p[3] & grp_p[2] & grp_p[1] & grp_g[0])
                 | (grp_p[3] & grp_p[2] & grp_p[1] & grp_p[0] & gc[0]);

    assign raw_sum  = p ^ carry;
    assign ovfl_raw = gc[4] ^ carry[15];

`ifdef SATURATE_ARITH_EN
    always_comb begin
        sum_d = raw_sum;
        if (ovfl_raw)
            sum_d = a[15] ? 16'h8000 : 16'h7FFF;
    end
`else
    assign sum_d = raw_sum;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            sum       <= 16'h0000;
            ovfl      <= 1'b0;
            cout      <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                sum  <= sum_d;
                ovfl <= ovfl_raw;
                cout <= gc[4];
            end
        end
    end

endmodule

// File: tb/tb_adder_sub_16bit.sv
// Self-checking bench for adder_sub_16bit: directed boundary cases
// plus random regression against an integer-arithmetic model.
module tb_adder_sub_16bit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [15:0] a;
    logic [15:0] b;
    logic        is_sub;
    logic        out_valid;
    logic [15:0] sum;
    logic        ovfl;
    logic        cout;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    adder_sub_16bit dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .is_sub    (is_sub),
        .out_valid (out_valid),
        .sum       (sum),
        .ovfl      (ovfl),
        .cout      (cout)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Returns {ovfl, cout, sum} from plain signed/unsigned arithmetic
    function automatic logic [17:0] model(input logic [15:0] x,
                                          input logic [15:0] y,
                                          input logic s);
        int sx;
        int sy;
        int res;
        logic v;
        logic c;
        logic [15:0] r;
        sx  = int'($signed(x));
        sy  = int'($signed(y));
        res = s ? sx - sy : sx + sy;
        v   = (res > 32767) || (res < -32768);
        if (s)
            c = (int'(x) >= int'(y));
        else
            c = (int'(x) + int'(y)) > 65535;
        r = res[15:0];
`ifdef SATURATE_ARITH_EN
        if (v)
            r = (res > 0) ? 16'h7FFF : 16'h8000;
`endif
        return {v, c, r};
    endfunction

    task automatic do_op(input string tag, input logic [15:0] x,
                         input logic [15:0] y, input logic s);
        logic [17:0] e;
        @(negedge clk);
        a = x;
        b = y;
        is_sub = s;
        in_valid = 1'b1;
        e = model(x, y, s);
        @(posedge clk);
        #1;
        chk({tag, ".vld"}, 32'(out_valid), 32'd1);
        chk({tag, ".sum"}, 32'(sum), 32'(e[15:0]));
        chk({tag, ".ovf"}, 32'(ovfl), 32'(e[17]));
        chk({tag, ".co"},  32'(cout), 32'(e[16]));
    endtask

    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
        logic        s;
        logic [15:0] wrap;
        logic [15:0] sat;
        logic        v;
        logic        c;
    } vec_t;

    vec_t vecs[7];

    initial begin
        vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 16'h5555, 1'b0, 1'b0};
        vecs[1] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 16'h7FFF, 1'b1, 1'b0};
        vecs[2] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 16'h8000, 1'b1, 1'b1};
        vecs[3] = '{16'hFFFF, 16'hFFFE, 1'b0, 16'hFFFD, 16'hFFFD, 1'b0, 1'b1};
        vecs[4] = '{16'hFFFF, 16'hFFFE, 1'b1, 16'h0001, 16'h0001, 1'b0, 1'b1};
        vecs[5] = '{16'h0000, 16'h8000, 1'b1, 16'h8000, 16'h7FFF, 1'b1, 1'b0};
        vecs[6] = '{16'h8000, 16'h8000, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b1};

        rst = 1'b1;
        in_valid = 1'b0;
        a = '0;
        b = '0;
        is_sub = 1'b0;
        #1;
        chk("rst0.vld", 32'(out_valid), 32'd0);
        chk("rst0.sum", 32'(sum), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Directed cases against hand-derived constants
        foreach (vecs[i]) begin
            @(negedge clk);
            a = vecs[i].x;
            b = vecs[i].y;
            is_sub = vecs[i].s;
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            chk($sformatf("dir%0d.vld", i), 32'(out_valid), 32'd1);
`ifdef SATURATE_ARITH_EN
            chk($sformatf("dir%0d.sum", i), 32'(sum), 32'(vecs[i].sat));
`else
            chk($sformatf("dir%0d.sum", i), 32'(sum), 32'(vecs[i].wrap));
`endif
            chk($sformatf("dir%0d.ovf", i), 32'(ovfl), 32'(vecs[i].v));
            chk($sformatf("dir%0d.co", i), 32'(cout), 32'(vecs[i].c));
        end

        // Idle cycle: valid drops, result holds
        @(negedge clk);
        in_valid = 1'b0;
        a = 16'hAAAA;
        b = 16'h5555;
        @(posedge clk);
        #1;
        chk("hold.vld", 32'(out_valid), 32'd0);
        chk("hold.sum", 32'(sum), 32'h0000);
        chk("hold.co", 32'(cout), 32'd1);

        // Asynchronous reset between clock edges
        do_op("pre", 16'h1234, 16'h4321, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst.vld", 32'(out_valid), 32'd0);
        chk("arst.sum", 32'(sum), 32'd0);
        chk("arst.ovf", 32'(ovfl), 32'd0);
        chk("arst.co", 32'(cout), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Reset coinciding with a valid op discards it
        do_op("pre2", 16'hFFFF, 16'hFFFE, 1'b0);
        @(negedge clk);
        a = 16'h7FFF;
        b = 16'h0001;
        is_sub = 1'b0;
        in_valid = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rstv.vld", 32'(out_valid), 32'd0);
        chk("rstv.sum", 32'(sum), 32'd0);
        chk("rstv.ovf", 32'(ovfl), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        do_op("post", 16'h0003, 16'h0005, 1'b1);

        // Random back-to-back regression
        for (int n = 0; n < 10000; n++)
            do_op("rnd", 16'($urandom), 16'($urandom),
                  1'($urandom_range(1, 0)));

        @(negedge clk);
        in_valid = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/adder_sub_16bit.md
Name: adder_sub_16bit

Overview:
16-bit two's-complement adder/subtractor with signed-overflow detection, built as four 4-bit carry-lookahead groups with a group-level lookahead unit. Serves as the ALU ADD/SUB datapath and the PC/address adder. Result and flags are registered, giving one cycle of latency, with a valid bit travelling alongside.

Parameters:
None. The width is fixed at 16 bits.

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operands on a, b and is_sub are valid this cycle
a  input  16  operand A, signed two's complement
b  input  16  operand B, signed two's complement
is_sub  input  1  0 = A+B, 1 = A-B
out_valid  output  1  sum and ovfl hold a new result
sum  output  16  registered result
ovfl  output  1  registered signed-overflow flag
cout  output  1  registered carry out of bit 15 (used for unsigned compare)

Behaviour:
- Reset: while rst is high, asynchronously force sum=16'h0000, ovfl=0, cout=0, out_valid=0.
- Operand conditioning:
  - b_eff = b XOR {16{is_sub}}.
  - Carry-in cin = is_sub. Subtraction is A + ~B + 1.
- Adder structure:
  - Per bit: generate g = a & b_eff, propagate p = a ^ b_eff.
  - Each 4-bit group produces group G/P and its internal carries by lookahead.
  - The group-level lookahead unit computes c4, c8, c12 and c16 from the group G/P values and cin.
  - The raw sum is p ^ carry, modulo 2^16 (wrap-around).
- Overflow:
  - ovfl_raw = (a[15] == b_eff[15]) && (raw_sum[15] != a[15]).
  - Equivalently ovfl_raw = c16 XOR c15.
  - Computed the same way for add and subtract.
- cout = c16. For subtraction, cout=1 means no borrow (A >= B unsigned).
- Timing:
  - On the rising clk edge with in_valid=1, register the result, ovfl, cout, and set out_valid=1.
  - With in_valid=0, out_valid goes to 0 and sum/ovfl/cout hold their previous values.
  - Latency is exactly one cycle. A new operation is accepted every cycle; there is no backpressure.
- Boundary cases:
  - 0x0000 - 0x8000 → 0x8000 with ovfl=1.
  - 0x8000 - 0x8000 → 0x0000, ovfl=0, cout=1.
  - Sum of two negatives with no overflow (0xFFFF + 0xFFFE) → 0xFFFD, ovfl=0, cout=1.
- Reset mid-operation: if rst is asserted on the same cycle as in_valid, reset wins and the operation is discarded. After rst deasserts, the first in_valid cycle produces a valid result on the next edge.
- Inputs must not contain X while in_valid=1. Behaviour with X inputs is undefined.

Optional Feature:
SATURATE_ARITH_EN
- Defined: when ovfl_raw=1, the registered sum saturates.
  - Positive overflow (a[15]=0) → 16'h7FFF.
  - Negative overflow (a[15]=1) → 16'h8000.
  - ovfl still reports 1. cout is unaffected and reflects the raw carry.
- Not defined: the registered sum is the raw modulo-2^16 result. No saturation logic is synthesized.

Test Plan:
- Reset and stimulus:
  - Assert rst asynchronously with no clock edge → sum=0, ovfl=0, cout=0, out_valid=0 immediately.
  - Then apply a=0x1234, b=0x4321, is_sub=0, in_valid=1 → one cycle later sum=0x5555, ovfl=0, out_valid=1.
- Positive overflow: a=0x7FFF, b=0x0001, is_sub=0 → sum=0x8000, ovfl=1. With SATURATE_ARITH_EN → sum=0x7FFF, ovfl=1.
- Negative overflow: a=0x8000, b=0x0001, is_sub=1 → sum=0x7FFF, ovfl=1, cout=1. With SATURATE_ARITH_EN → sum=0x8000.
- Negative operands, no overflow:
  - a=0xFFFF, b=0xFFFE, is_sub=0 → sum=0xFFFD, ovfl=0, cout=1.
  - Same operands with is_sub=1 → sum=0x0001, ovfl=0.
- Edge cases:
  - a=0x0000, b=0x8000, is_sub=1 → sum=0x8000, ovfl=1.
  - Deassert in_valid → out_valid=0, sum holds.
  - Assert rst in the same cycle as a valid op → outputs reset, operation dropped.
- Random regression: 10k random a, b, is_sub each cycle, checked against a behavioural model of the 17-bit sum and signed overflow, one-cycle delayed, in both macro builds.
